// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // 64-bit result so that 10^10 still fits for the widest digit count.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative (one bit per cycle) double-dabble binary-to-BCD converter with
// overflow saturation and a leading-zero mask.
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int                  ACC_W     = 4*DIGITS + 4;
  localparam int                  CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0]         OVF_LIMIT = pow10(DIGITS);
  localparam logic [DIGITS-1:0]   LZ_RESET  = ~DIGITS'(1);
  localparam logic [4*DIGITS-1:0] BCD_SAT   = {DIGITS{4'h9}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BIN_W-1:0]    sr_q, sr_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   lz_q, lz_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [4*DIGITS-1:0] res_bcd;
  logic [DIGITS-1:0]   res_lz;
  logic                zero_run;
  logic                capture;

  // The extra top digit keeps overflow digits from wrapping into the result.
  for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    res_bcd  = ovf_pend_q ? BCD_SAT : acc_q[4*DIGITS-1:0];
    res_lz   = '0;
    zero_run = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      zero_run  = zero_run & (res_bcd[4*i +: 4] == 4'd0);
      res_lz[i] = zero_run;
    end
  end

  // Results are published on the edge that leaves DONE, so a held start
  // restarts on that same edge and keeps a BIN_W+1 cycle cadence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    lz_d       = lz_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        capture = start;
      end
      SHIFT: begin
        acc_d      = {acc_adj[ACC_W-2:0], sr_q[BIN_W-1]};
        sr_d       = {sr_q[BIN_W-2:0], 1'b0};
        ovf_pend_d = ovf_pend_q | acc_adj[ACC_W-1];
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        bcd_d   = res_bcd;
        ovf_d   = ovf_pend_q;
        lz_d    = res_lz;
        capture = start;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      state_d    = SHIFT;
      cnt_d      = CNT_W'(BIN_W);
      acc_d      = '0;
      sr_d       = binary_in;
      ovf_pend_d = (64'(binary_in) >= OVF_LIMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sr_q       <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      lz_q       <= LZ_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      lz_q       <= lz_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign lz_mask = lz_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Scoreboard bench for bin2bcd_iter: default, two-digit (saturating) and
// 16-bit/5-digit instances share one clock and reset.
`timescale 1ns/1ps
module tb_bin2bcd_iter;

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    logic [9:0]  lz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0, busy_a, done_a, ovf_a;
  logic [6:0]  bin_a = '0;
  logic [11:0] bcd_a;
  logic [2:0]  lz_a;

  logic        start_b = 1'b0, busy_b, done_b, ovf_b;
  logic [6:0]  bin_b = '0;
  logic [7:0]  bcd_b;
  logic [1:0]  lz_b;

  logic        start_c = 1'b0, busy_c, done_c, ovf_c;
  logic [15:0] bin_c = '0;
  logic [19:0] bcd_c;
  logic [4:0]  lz_c;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bin2bcd_iter u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .binary_in(bin_a), .busy(busy_a),
    .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a), .lz_mask(lz_a)
  );

  bin2bcd_iter #(.BIN_W(7), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .binary_in(bin_b), .busy(busy_b),
    .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b), .lz_mask(lz_b)
  );

  bin2bcd_iter #(.BIN_W(16), .DIGITS(5)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .binary_in(bin_c), .busy(busy_c),
    .done(done_c), .bcd_out(bcd_c), .ovf(ovf_c), .lz_mask(lz_c)
  );

  // Reference model: decimal digits by repeated division.
  task automatic push_exp(input longint unsigned v, input int nd);
    exp_t e;
    longint unsigned lim = 1;
    longint unsigned t = v;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.ovf = (v >= lim);
    e.bcd = '0;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = e.ovf ? 4'd9 : 4'(t % 10);
      t = t / 10;
    end
    e.lz = '0;
    for (int i = 1; i < nd; i++) e.lz[i] = ((e.bcd >> (4*i)) == 40'd0);
    sbq.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sbq.size() == 0) begin
      e.bcd = 'x;
      e.ovf = 1'bx;
      e.lz  = 'x;
    end else begin
      e = sbq.pop_front();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Returns the edge count at which done was seen, or -1 when the budget runs out.
  task automatic wait_done(input int which, input int limit, output int edges);
    edges = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (done_of(which)) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (bcd_a !== 12'h000) begin failures++; $display("[TB] FAIL reset_bcd got=%h exp=000", bcd_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_a); end
    checks++; if (lz_a !== 3'b110) begin failures++; $display("[TB] FAIL reset_lz_a got=%b exp=110", lz_a); end
    checks++; if (lz_b !== 2'b10) begin failures++; $display("[TB] FAIL reset_lz_b got=%b exp=10", lz_b); end
    checks++; if (lz_c !== 5'b11110) begin failures++; $display("[TB] FAIL reset_lz_c got=%b exp=11110", lz_c); end
    checks++; if (busy_c !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_c got=%b exp=0", busy_c); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    int   edges;
    bin_a   = 7'd127;
    start_a = 1'b1;
    push_exp(127, 3);
    tick();
    start_a = 1'b0;
    bin_a   = 7'h55;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=1", busy_a); end
    wait_done(0, 40, edges);
    checks++; if (edges != 8) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=8", edges); end
    pop_exp(e);
    checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL basic_bcd got=%h exp=%h", bcd_a, e.bcd[11:0]); end
    checks++; if (ovf_a !== e.ovf) begin failures++; $display("[TB] FAIL basic_ovf got=%b exp=%b", ovf_a, e.ovf); end
    checks++; if (lz_a !== e.lz[2:0]) begin failures++; $display("[TB] FAIL basic_lz got=%b exp=%b", lz_a, e.lz[2:0]); end
    tick();
    checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse got=%b exp=0", done_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle got=%b exp=0", busy_a); end
    checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL basic_hold got=%h exp=%h", bcd_a, e.bcd[11:0]); end
  endtask

  task automatic test_values();
    int   vals[7] = '{0, 5, 9, 10, 99, 100, 126};
    exp_t e;
    int   edges;
    foreach (vals[k]) begin
      bin_a   = 7'(vals[k]);
      start_a = 1'b1;
      push_exp(longint'(vals[k]), 3);
      tick();
      start_a = 1'b0;
      wait_done(0, 40, edges);
      checks++; if (edges != 8) begin failures++; $display("[TB] FAIL values_latency v=%0d got=%0d exp=8", vals[k], edges); end
      pop_exp(e);
      checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL values_bcd v=%0d got=%h exp=%h", vals[k], bcd_a, e.bcd[11:0]); end
      checks++; if (ovf_a !== e.ovf) begin failures++; $display("[TB] FAIL values_ovf v=%0d got=%b exp=%b", vals[k], ovf_a, e.ovf); end
      checks++; if (lz_a !== e.lz[2:0]) begin failures++; $display("[TB] FAIL values_lz v=%0d got=%b exp=%b", vals[k], lz_a, e.lz[2:0]); end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    exp_t        e;
    int          pulses = 0;
    int          first_edge = -1;
    bit          glitch = 1'b0;
    logic [11:0] prev;
    prev    = bcd_a;
    bin_a   = 7'd99;
    start_a = 1'b1;
    push_exp(99, 3);
    tick();
    start_a = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 3) begin
        bin_a   = 7'd55;
        start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      tick();
      if (done_a) begin
        pulses++;
        if (first_edge < 0) first_edge = n;
      end
      if (first_edge < 0 && bcd_a !== prev) glitch = 1'b1;
    end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL ignore_pulses got=%0d exp=1", pulses); end
    checks++; if (first_edge != 8) begin failures++; $display("[TB] FAIL ignore_latency got=%0d exp=8", first_edge); end
    checks++; if (glitch !== 1'b0) begin failures++; $display("[TB] FAIL ignore_midchange got=%b exp=0", glitch); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL ignore_restart got=%b exp=0", busy_a); end
    pop_exp(e);
    checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL ignore_bcd got=%h exp=%h", bcd_a, e.bcd[11:0]); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   pulses = 0;
    int   edges;
    bin_a   = 7'd77;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #2;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy_a); end
    checks++; if (bcd_a !== 12'h000) begin failures++; $display("[TB] FAIL abort_bcd got=%h exp=000", bcd_a); end
    checks++; if (lz_a !== 3'b110) begin failures++; $display("[TB] FAIL abort_lz got=%b exp=110", lz_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_ovf got=%b exp=0", ovf_a); end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done_a) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL abort_nodone got=%0d exp=0", pulses); end
    bin_a   = 7'd64;
    start_a = 1'b1;
    push_exp(64, 3);
    tick();
    start_a = 1'b0;
    wait_done(0, 40, edges);
    checks++; if (edges != 8) begin failures++; $display("[TB] FAIL abort_latency got=%0d exp=8", edges); end
    pop_exp(e);
    checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL abort_bcd64 got=%h exp=%h", bcd_a, e.bcd[11:0]); end
    tick();
  endtask

  task automatic test_overflow();
    int   vals[5] = '{100, 42, 99, 127, 0};
    exp_t e;
    int   edges;
    foreach (vals[k]) begin
      bin_b   = 7'(vals[k]);
      start_b = 1'b1;
      push_exp(longint'(vals[k]), 2);
      tick();
      start_b = 1'b0;
      wait_done(1, 40, edges);
      checks++; if (edges != 8) begin failures++; $display("[TB] FAIL ovf_latency v=%0d got=%0d exp=8", vals[k], edges); end
      pop_exp(e);
      checks++; if (bcd_b !== e.bcd[7:0]) begin failures++; $display("[TB] FAIL ovf_bcd v=%0d got=%h exp=%h", vals[k], bcd_b, e.bcd[7:0]); end
      checks++; if (ovf_b !== e.ovf) begin failures++; $display("[TB] FAIL ovf_flag v=%0d got=%b exp=%b", vals[k], ovf_b, e.ovf); end
      checks++; if (lz_b !== e.lz[1:0]) begin failures++; $display("[TB] FAIL ovf_lz v=%0d got=%b exp=%b", vals[k], lz_b, e.lz[1:0]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int   vals_a[5];
    int   vals_c[2] = '{65535, 1};
    exp_t e;
    int   edges;
    foreach (vals_a[k]) vals_a[k] = int'($urandom_range(0, 127));
    bin_a   = 7'(vals_a[0]);
    start_a = 1'b1;
    push_exp(longint'(vals_a[0]), 3);
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) begin
        bin_a = 7'(vals_a[k]);
        push_exp(longint'(vals_a[k]), 3);
      end else begin
        start_a = 1'b0;
      end
      wait_done(0, 20, edges);
      checks++; if (edges != 8) begin failures++; $display("[TB] FAIL b2b_a_period k=%0d got=%0d exp=8", k, edges); end
      pop_exp(e);
      checks++; if (bcd_a !== e.bcd[11:0]) begin failures++; $display("[TB] FAIL b2b_a_bcd k=%0d got=%h exp=%h", k, bcd_a, e.bcd[11:0]); end
      checks++; if (lz_a !== e.lz[2:0]) begin failures++; $display("[TB] FAIL b2b_a_lz k=%0d got=%b exp=%b", k, lz_a, e.lz[2:0]); end
    end
    tick();

    bin_c   = 16'(vals_c[0]);
    start_c = 1'b1;
    push_exp(longint'(vals_c[0]), 5);
    tick();
    for (int k = 1; k <= 2; k++) begin
      if (k < 2) begin
        bin_c = 16'(vals_c[k]);
        push_exp(longint'(vals_c[k]), 5);
      end else begin
        start_c = 1'b0;
      end
      wait_done(2, 40, edges);
      checks++; if (edges != 17) begin failures++; $display("[TB] FAIL b2b_c_period k=%0d got=%0d exp=17", k, edges); end
      pop_exp(e);
      checks++; if (bcd_c !== e.bcd[19:0]) begin failures++; $display("[TB] FAIL b2b_c_bcd k=%0d got=%h exp=%h", k, bcd_c, e.bcd[19:0]); end
      checks++; if (ovf_c !== e.ovf) begin failures++; $display("[TB] FAIL b2b_c_ovf k=%0d got=%b exp=%b", k, ovf_c, e.ovf); end
      checks++; if (lz_c !== e.lz[4:0]) begin failures++; $display("[TB] FAIL b2b_c_lz k=%0d got=%b exp=%b", k, lz_c, e.lz[4:0]); end
    end
    tick();
    checks++; if (busy_c !== 1'b0) begin failures++; $display("[TB] FAIL b2b_c_idle got=%b exp=0", busy_c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_reset_abort();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
